// File: rtl/univ_shift_reg.sv
// Universal shift register with a hold/load/shift/rotate/clear datapath and an
// N-step sequencer driven by a start/busy/done handshake.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  output logic [WIDTH-1:0] q,
  output logic             ser_out_l,
  output logic             ser_out_r,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_SHR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] q_nx;
  logic [AMT_W-1:0] cnt;
  logic [AMT_W-1:0] cnt_nx;
  logic [2:0]       smode;
  logic [2:0]       smode_nx;
  logic             launch;

  // One register step for the given op; serial inputs are used as they are now.
  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] ld,
    input logic             sl,
    input logic             sr
  );
    logic [WIDTH-1:0] res;
    case (op)
      OP_HOLD: res = cur;
      OP_LOAD: res = ld;
      OP_SHL:  res = {cur[WIDTH-2:0], sr};
      OP_SHR:  res = {sl, cur[WIDTH-1:1]};
      OP_ROL:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
      OP_ROR:  res = {cur[0], cur[WIDTH-1:1]};
      OP_ASR:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
      OP_CLR:  res = {WIDTH{1'b0}};
      default: res = cur;
    endcase
    return res;
  endfunction

  // Only the shift/rotate family can be sequenced; hold/load/clear stay direct ops.
  assign launch = start && (mode >= OP_SHL) && (mode <= OP_ASR);

  // Next-state, next-data and step-count logic.
  always_comb begin
    state_nx = state;
    q_nx     = q;
    cnt_nx   = cnt;
    smode_nx = smode;
    case (state)
      IDLE: begin
        if (launch) begin
          smode_nx = mode;
          cnt_nx   = amount;
          if (amount != {AMT_W{1'b0}}) begin
            state_nx = RUN;
          end else begin
            state_nx = DONE;
          end
        end else if (en) begin
          q_nx = apply_op(mode, q, load_data, ser_in_l, ser_in_r);
        end else begin
          q_nx = q;
        end
      end
      RUN: begin
        if (en) begin
          q_nx   = apply_op(smode, q, load_data, ser_in_l, ser_in_r);
          cnt_nx = cnt - {{(AMT_W-1){1'b0}}, 1'b1};
          if (cnt == {{(AMT_W-1){1'b0}}, 1'b1}) begin
            state_nx = DONE;
          end else begin
            state_nx = RUN;
          end
        end else begin
          state_nx = RUN;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State, data and handshake registers; busy/done decode the upcoming state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      q     <= {WIDTH{1'b0}};
      cnt   <= {AMT_W{1'b0}};
      smode <= OP_HOLD;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      q     <= q_nx;
      cnt   <= cnt_nx;
      smode <= smode_nx;
      busy  <= (state_nx == RUN);
      done  <= (state_nx == DONE);
    end
  end

  assign ser_out_l = q[WIDTH-1];
  assign ser_out_r = q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg: an arithmetic reference model queues the
// expected outputs per clock and a negedge monitor compares them to the DUT.
module tb_univ_shift_reg;

  localparam int W    = 8;
  localparam int AW   = 4;
  localparam int TOP  = 1 << W;
  localparam int HALF = 1 << (W - 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [2:0]    mode;
  logic [W-1:0]  load_data;
  logic          ser_in_l;
  logic          ser_in_r;
  logic          start;
  logic [AW-1:0] amount;
  logic [W-1:0]  q;
  logic          ser_out_l;
  logic          ser_out_r;
  logic          busy;
  logic          done;

  univ_shift_reg #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load_data(load_data),
    .ser_in_l(ser_in_l), .ser_in_r(ser_in_r), .start(start), .amount(amount),
    .q(q), .ser_out_l(ser_out_l), .ser_out_r(ser_out_r), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q;
    bit busy;
    bit done;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: phase 0 idle, 1 sequencing, 2 completion cycle.
  int m_q, m_phase, m_rem, m_smode;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int apply_op(input int op, input int cur, input int ld,
                                  input int sl, input int sr);
    case (op)
      0: return cur;
      1: return ld;
      2: return (cur * 2 + sr) % TOP;
      3: return cur / 2 + sl * HALF;
      4: return (cur * 2) % TOP + cur / HALF;
      5: return cur / 2 + (cur % 2) * HALF;
      6: return cur / 2 + (cur / HALF) * HALF;
      7: return 0;
      default: return cur;
    endcase
  endfunction

  task automatic model_edge();
    case (m_phase)
      0: begin
        if (start && mode >= 2 && mode <= 6) begin
          m_smode = int'(mode);
          m_rem   = int'(amount);
          m_phase = (m_rem != 0) ? 1 : 2;
        end else if (en) begin
          m_q = apply_op(int'(mode), m_q, int'(load_data), int'(ser_in_l), int'(ser_in_r));
        end
      end
      1: begin
        if (en) begin
          m_q = apply_op(m_smode, m_q, int'(load_data), int'(ser_in_l), int'(ser_in_r));
          m_rem--;
          if (m_rem == 0) m_phase = 2;
        end
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic push_exp();
    exp_t e;
    e.q    = m_q;
    e.busy = (m_phase == 1);
    e.done = (m_phase == 2);
    exp_q.push_back(e);
  endtask

  // One clock: model follows the inputs present at the edge, expectation queued.
  task automatic cycle();
    @(posedge clk);
    #1;
    model_edge();
    push_exp();
  endtask

  task automatic set_in(input bit e, input int md, input bit st, input int amt, input int ld);
    en        = e;
    mode      = md[2:0];
    start     = st;
    amount    = amt[AW-1:0];
    load_data = ld[W-1:0];
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_q", int'(q), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_done", int'(done), 0);
    m_q = 0; m_phase = 0; m_rem = 0; m_smode = 0;
    @(posedge clk);
    #1;
    push_exp();
    rst = 1'b0;
  endtask

  // Monitor: the DUT presents a new register state every cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("q", int'(q), e.q);
      check("busy", int'(busy), int'(e.busy));
      check("done", int'(done), int'(e.done));
      check("ser_out_l", int'(ser_out_l), (e.q / HALF) % 2);
      check("ser_out_r", int'(ser_out_r), e.q % 2);
    end
  end

  initial begin
    rst = 1'b1;
    set_in(1'b0, 0, 1'b0, 0, 0);
    ser_in_l = 1'b0;
    ser_in_r = 1'b0;
    m_q = 0; m_phase = 0; m_rem = 0; m_smode = 0;
    #2;
    check("reset_q", int'(q), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Direct ops.
    set_in(1'b1, 1, 1'b0, 0, 8'hA5); cycle(); check("t2_load", int'(q), 8'hA5);
    set_in(1'b1, 4, 1'b0, 0, 0);     cycle(); check("t2_rol", int'(q), 8'h4B);
    set_in(1'b1, 5, 1'b0, 0, 0);     cycle(); check("t2_ror", int'(q), 8'hA5);
    set_in(1'b1, 6, 1'b0, 0, 0);     cycle(); check("t2_asr", int'(q), 8'hD2);
    set_in(1'b1, 7, 1'b0, 0, 0);     cycle(); check("t2_clr", int'(q), 8'h00);

    // SHL x3 with ones filling; start/LOAD during the run must be ignored.
    set_in(1'b1, 1, 1'b0, 0, 8'h81); cycle();
    ser_in_r = 1'b1;
    set_in(1'b1, 2, 1'b1, 3, 0);     cycle();
    set_in(1'b1, 1, 1'b0, 0, 8'hFF); cycle();
    set_in(1'b1, 3, 1'b1, 1, 8'hFF); cycle();
    set_in(1'b1, 1, 1'b0, 0, 8'hFF); cycle();
    check("t3_q", int'(q), 8'h0F);
    check("t3_done", int'(done), 1);
    set_in(1'b0, 0, 1'b0, 0, 0);     cycle();
    ser_in_r = 1'b0;

    // ROR x4 on 8'h01 with a two-cycle pause.
    set_in(1'b1, 1, 1'b0, 0, 8'h01); cycle();
    set_in(1'b1, 5, 1'b1, 4, 0);     cycle();
    set_in(1'b1, 0, 1'b0, 0, 0);     cycle();
    en = 1'b0; cycle(); cycle();
    check("t4_paused_busy", int'(busy), 1);
    en = 1'b1; cycle(); cycle(); cycle();
    check("t4_q", int'(q), 8'h10);
    check("t4_done", int'(done), 1);
    set_in(1'b0, 0, 1'b0, 0, 0);     cycle();

    // Zero-length sequence.
    set_in(1'b1, 3, 1'b1, 0, 0);     cycle();
    check("t5_busy", int'(busy), 0);
    check("t5_done", int'(done), 1);
    check("t5_q", int'(q), 8'h10);
    set_in(1'b0, 0, 1'b0, 0, 0);     cycle();

    // Reset in the middle of a long run; no completion afterwards.
    set_in(1'b1, 1, 1'b0, 0, 8'h3C); cycle();
    set_in(1'b1, 4, 1'b1, 8, 0);     cycle();
    set_in(1'b1, 0, 1'b0, 0, 0);     cycle(); cycle();
    mid_reset();
    for (int i = 0; i < 10; i++) cycle();

    // Randomised traffic; en is held low in the completion cycle.
    for (int i = 0; i < 600; i++) begin
      set_in(($urandom % 4) != 0, int'($urandom % 8), ($urandom % 5) == 0,
             int'($urandom_range(0, 6)), int'($urandom % TOP));
      if (m_phase == 2) en = 1'b0;
      ser_in_l = 1'($urandom % 2);
      ser_in_r = 1'($urandom % 2);
      cycle();
    end

    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
